serial_deser: RTL and testbench
===============================

SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning assembled word width in bits; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in out_data[WIDTH-1], 0 = first received bit lands in out_data[0].
REQ-003 SHALL have port clk_in  input  1  clock; one clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port serial_in  input  1  serial data bit, sampled when wr_in=1.
REQ-006 SHALL have port wr_in  input  1  bit strobe; one bit accepted per cycle with wr_in=1.
REQ-007 SHALL have port clr_in  input  1  abort partial word and clear overrun_err.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-009 SHALL have port in_rdy  output  1  high when no partial word is held (state IDLE).
REQ-010 SHALL have port out_valid  output  1  out_data holds a complete, unconsumed word.
REQ-011 SHALL have port out_data  output  WIDTH  assembled word.
REQ-012 SHALL have port bit_cnt  output  $clog2(WIDTH+1)  bits accepted into current partial word.
REQ-013 SHALL have port overrun_err  output  1  sticky, set when a completed word is dropped.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (bit_cnt=0) and SHIFT (0<bit_cnt<WIDTH).
REQ-015 IDLE->SHIFT SHALL occur on wr_in=1; SHIFT->IDLE SHALL occur on the cycle the WIDTH-th bit is accepted, or on clr_in=1.
REQ-016 With MSB_FIRST=1, each accepted bit SHALL shift the internal register left with serial_in entering bit 0; with MSB_FIRST=0, shift right with serial_in entering bit WIDTH-1.
REQ-017 bit_cnt SHALL increment by 1 per accepted bit and return to 0 on the edge completing the word (no wrap through WIDTH).
REQ-018 On the edge accepting the WIDTH-th bit, the completed word (including that bit) SHALL load into out_data and out_valid SHALL be 1 from the next cycle: latency 1 clock from final strobe.
REQ-019 Word transfer SHALL occur on any edge where out_valid=1 and out_ready=1; out_valid then clears unless a new word loads on the same edge.
REQ-020 Completion while out_valid=1 and out_ready=1 SHALL load the new word, keep out_valid=1, and not set overrun_err.
REQ-021 Completion while out_valid=1 and out_ready=0 SHALL drop the new word, retain old out_data, and set overrun_err.
REQ-022 out_data SHALL remain stable while out_valid=1 and not transferred; out_data SHALL hold its last value when out_valid=0.
REQ-023 clr_in=1 SHALL take priority over wr_in in the same cycle: bit discarded, bit_cnt->0, state->IDLE, overrun_err->0; out_valid/out_data SHALL be unaffected.
REQ-024 A word completing in the cycle clr_in=1 SHALL be discarded and not raise out_valid.
REQ-025 wr_in=0 SHALL hold internal register, bit_cnt and state unchanged; no timeout.
REQ-026 in_rdy SHALL be combinationally 1 exactly when state is IDLE.

Reset
REQ-027 On rst_in=1 at a clock edge: state=IDLE, bit_cnt=0, internal register=0, out_data=0, out_valid=0, overrun_err=0, hence in_rdy=1.
REQ-028 rst_in SHALL override clr_in, wr_in and out_ready; reset mid-word SHALL discard the partial word and any pending out_data.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive wr_in cycles -> out_valid=1 one cycle after 8th strobe, out_data=8'hB2, bit_cnt=0, in_rdy=1.
REQ-030 WIDTH=8, MSB_FIRST=0, same bit sequence -> out_data=8'h4D.
REQ-031 WIDTH=8, out_ready=0, two words 8'hB2 then 8'hFF -> out_data stays 8'hB2, overrun_err=1; then clr_in pulse -> overrun_err=0, out_valid still 1.
REQ-032 WIDTH=8, out_ready=1 held, back-to-back words 8'hB2, 8'h5A with no gaps -> out_valid pulses each one cycle, no overrun_err.
REQ-033 WIDTH=8, 5 bits sent, then rst_in pulse (or clr_in with wr_in=1) -> bit_cnt=0, in_rdy=1, no out_valid; next 8 bits 8'hB2 produce out_data=8'hB2.
REQ-034 WIDTH=32, MSB_FIRST=1, serialise 32'h3F800000 with random wr_in gaps -> out_data=32'h3F800000 exactly once.

Source files
------------

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: accepts one bit per wr_in strobe and presents
// each completed WIDTH-bit word on a valid/ready output with a sticky overrun flag.
module serial_deser #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       serial_in,
  input  logic                       wr_in,
  input  logic                       clr_in,
  input  logic                       out_ready,
  output logic                       in_rdy,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun_err
);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shift_nxt;
  logic             accept, done, xfer;

  assign shift_nxt = MSB_FIRST ? {shreg_q[WIDTH-2:0], serial_in}
                               : {serial_in, shreg_q[WIDTH-1:1]};
  assign accept    = wr_in & ~clr_in;
  assign done      = accept && (cnt_q == CW'(WIDTH-1));
  assign xfer      = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q & ~xfer;
    ovr_d   = ovr_q;
    if (clr_in) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (accept) begin
      shreg_d = shift_nxt;
      if (done) begin
        state_d = IDLE;
        cnt_d   = '0;
        // A held word that is not leaving this cycle wins; the new one is lost.
        if (!valid_q || out_ready) begin
          data_d  = shift_nxt;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign in_rdy      = (state_q == IDLE);
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign bit_cnt     = cnt_q;
  assign overrun_err = ovr_q;
endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: MSB- and LSB-first 8-bit instances plus a
// 32-bit instance, all sharing one stimulus stream.
module tb_serial_deser;
  logic gclk = 1'b0;
  logic rst, ser, wr, clr, rdy;

  logic       rdy_m, vld_m, ovr_m;
  logic [7:0] dat_m;
  logic [3:0] cnt_m;
  logic       rdy_l, vld_l, ovr_l;
  logic [7:0] dat_l;
  logic [3:0] cnt_l;
  logic        rdy_w, vld_w, ovr_w;
  logic [31:0] dat_w;
  logic [5:0]  cnt_w;

  int n_vec = 0;
  int n_err = 0;
  int n32   = 0;
  logic [31:0] last32 = '0;

  always #5 gclk = ~gclk;

  serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_in(gclk), .rst_in(rst), .serial_in(ser), .wr_in(wr), .clr_in(clr),
    .out_ready(rdy), .in_rdy(rdy_m), .out_valid(vld_m), .out_data(dat_m),
    .bit_cnt(cnt_m), .overrun_err(ovr_m));

  serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_in(gclk), .rst_in(rst), .serial_in(ser), .wr_in(wr), .clr_in(clr),
    .out_ready(rdy), .in_rdy(rdy_l), .out_valid(vld_l), .out_data(dat_l),
    .bit_cnt(cnt_l), .overrun_err(ovr_l));

  serial_deser #(.WIDTH(32), .MSB_FIRST(1'b1)) u_w32 (
    .clk_in(gclk), .rst_in(rst), .serial_in(ser), .wr_in(wr), .clr_in(clr),
    .out_ready(rdy), .in_rdy(rdy_w), .out_valid(vld_w), .out_data(dat_w),
    .bit_cnt(cnt_w), .overrun_err(ovr_w));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and track 32-bit word deliveries.
  task automatic tick();
    @(posedge gclk);
    #1;
    if (vld_w) begin
      n32++;
      last32 = dat_w;
    end
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  pat;
    logic [31:0] f32;
    rst = 1'b1; ser = 1'b0; wr = 1'b0; clr = 1'b0; rdy = 1'b0;
    do_reset();
    chk("rst_in_rdy", rdy_m, 1'b1);
    chk("rst_valid",  vld_m, 1'b0);
    chk("rst_data",   dat_m, 8'h00);
    chk("rst_cnt",    cnt_m, 4'd0);
    chk("rst_ovr",    ovr_m, 1'b0);

    // 1,0,1,1,0,0,1,0 on consecutive strobes
    pat = 8'hB2;
    for (int i = 7; i >= 5; i--) send_bit(pat[i]);
    chk("mid_cnt",    cnt_m, 4'd3);
    chk("mid_in_rdy", rdy_m, 1'b0);
    chk("mid_valid",  vld_m, 1'b0);
    for (int i = 4; i >= 0; i--) send_bit(pat[i]);
    chk("msb_valid",  vld_m, 1'b1);
    chk("msb_data",   dat_m, 8'hB2);
    chk("msb_cnt",    cnt_m, 4'd0);
    chk("msb_in_rdy", rdy_m, 1'b1);
    chk("lsb_data",   dat_l, 8'h4D);
    chk("lsb_valid",  vld_l, 1'b1);

    // second word while the first is still held -> dropped, overrun
    send_byte(8'hFF);
    chk("ovr_data",  dat_m, 8'hB2);
    chk("ovr_flag",  ovr_m, 1'b1);
    chk("ovr_valid", vld_m, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovr",   ovr_m, 1'b0);
    chk("clr_valid", vld_m, 1'b1);
    chk("clr_data",  dat_m, 8'hB2);
    rdy = 1'b1; tick();
    chk("xfer_valid", vld_m, 1'b0);
    chk("hold_data",  dat_m, 8'hB2);

    // back-to-back words with out_ready held high
    send_byte(8'hB2);
    chk("b2b_v1",   vld_m, 1'b1);
    chk("b2b_d1",   dat_m, 8'hB2);
    pat = 8'h5A;
    send_bit(pat[7]);
    chk("b2b_gap",  vld_m, 1'b0);
    for (int i = 6; i >= 0; i--) send_bit(pat[i]);
    chk("b2b_v2",   vld_m, 1'b1);
    chk("b2b_d2",   dat_m, 8'h5A);
    tick();
    chk("b2b_end",  vld_m, 1'b0);
    chk("b2b_ovr",  ovr_m, 1'b0);

    // completion on the same edge the held word is consumed
    rdy = 1'b0;
    send_byte(8'h3C);
    pat = 8'hC3;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    rdy = 1'b1;
    send_bit(pat[0]);
    chk("swap_valid", vld_m, 1'b1);
    chk("swap_data",  dat_m, 8'hC3);
    chk("swap_ovr",   ovr_m, 1'b0);
    tick();
    chk("swap_drain", vld_m, 1'b0);

    // clr with wr high aborts a partial word
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("part_cnt", cnt_m, 4'd5);
    clr = 1'b1; send_bit(1'b1); clr = 1'b0;
    chk("abort_cnt",   cnt_m, 4'd0);
    chk("abort_rdy",   rdy_m, 1'b1);
    chk("abort_valid", vld_m, 1'b0);
    send_byte(8'hB2);
    chk("after_abort", dat_m, 8'hB2);
    chk("after_abort_v", vld_m, 1'b1);
    rdy = 1'b1; tick(); rdy = 1'b0;

    // word completing under clr is discarded
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    clr = 1'b1; send_bit(1'b0); clr = 1'b0;
    chk("clr_done_valid", vld_m, 1'b0);
    chk("clr_done_cnt",   cnt_m, 4'd0);
    chk("clr_done_data",  dat_m, 8'hB2);

    // reset mid-word, with a pending word held
    send_byte(8'h81);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1; wr = 1'b1; rdy = 1'b1; tick(); rst = 1'b0; wr = 1'b0; rdy = 1'b0;
    chk("rstmid_cnt",   cnt_m, 4'd0);
    chk("rstmid_valid", vld_m, 1'b0);
    chk("rstmid_data",  dat_m, 8'h00);
    chk("rstmid_rdy",   rdy_m, 1'b1);
    send_byte(8'hB2);
    chk("rstmid_next",  dat_m, 8'hB2);

    // 32-bit word with random strobe gaps
    do_reset();
    n32 = 0;
    rdy = 1'b1;
    f32 = 32'h3F80_0000;
    for (int i = 31; i >= 0; i--) begin
      send_bit(f32[i]);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end
    for (int i = 0; i < 4; i++) tick();
    chk("w32_count", 64'(n32), 64'd1);
    chk("w32_data",  last32, 32'h3F80_0000);
    chk("w32_ovr",   ovr_w, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
